// File: rtl/alu_mdu.sv
// alu_mdu -- execute-stage integer unit: base ALU plus an RV32M-style
// multiply/divide unit behind a start/done handshake.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high reset (aborts any in-flight operation)
//   start  : operation request, only sampled while busy=0
//   op     : 5-bit operation select
//   a, b   : operands (rs1, rs2/imm); shifts use b[SHAMT_W-1:0]
//   busy   : multi-cycle operation in progress, start is ignored
//   done   : one-cycle pulse, result/zero valid
//   result : registered result, holds until the next done
//   zero   : registered (result == 0)
//
// Build option: define ALU_MDU_FAST_MUL_EN to replace the iterative
// shift-add multiplier with a single-cycle 2*WIDTH-bit multiplier. Division
// is iterative in both builds.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLL    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]         r_state;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [SHAMT_W-1:0] r_count;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_signA;
  logic               w_signB;
  logic               w_divZero;
  logic               w_divOvf;
  logic               w_single;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_quick;

  assign w_shamt = b[SHAMT_W-1:0];
  assign w_isMul = (op >= OP_MUL) && (op <= OP_MULHU);
  assign w_isDiv = (op >= OP_DIV) && (op <= OP_REMU);

  // Which operands are treated as two's complement for the requested op.
  assign w_signA = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
  assign w_signB = (op == OP_MUL) || (op == OP_MULH) ||
                   (op == OP_DIV) || (op == OP_REM);

  // The iterative engines work on magnitudes; signs are re-applied on exit.
  // The most-negative value's magnitude still fits as an unsigned WIDTH word.
  assign w_magA = (w_signA && a[WIDTH-1]) ? -a : a;
  assign w_magB = (w_signB && b[WIDTH-1]) ? -b : b;

  // Divide corner cases are answered immediately instead of iterating.
  assign w_divZero = w_isDiv && (b == '0);
  assign w_divOvf  = ((op == OP_DIV) || (op == OP_REM)) &&
                     (a == MOST_NEG) && (b == ALL_ONES);

`ifdef ALU_MDU_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] w_fastA;
  logic signed [2*WIDTH-1:0] w_fastB;
  logic signed [2*WIDTH-1:0] w_fastProd;

  // Extending each operand to 2*WIDTH by its signedness makes a single
  // signed multiply correct for all four multiply flavours.
  assign w_fastA    = {{WIDTH{w_signA & a[WIDTH-1]}}, a};
  assign w_fastB    = {{WIDTH{w_signB & b[WIDTH-1]}}, b};
  assign w_fastProd = w_fastA * w_fastB;
  assign w_single   = !w_isDiv || w_divZero || w_divOvf;
`else
  assign w_single   = !(w_isMul || w_isDiv) || w_divZero || w_divOvf;
`endif

  // Results of everything that completes at the accept edge.
  always_comb begin
    w_quick = '0;
    case (op)
      OP_ADD:  w_quick = a + b;
      OP_SUB:  w_quick = a - b;
      OP_AND:  w_quick = a & b;
      OP_OR:   w_quick = a | b;
      OP_XOR:  w_quick = a ^ b;
      OP_SLT:  w_quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_quick = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRL:  w_quick = a >> w_shamt;
      OP_SRA:  w_quick = $signed(a) >>> w_shamt;
      OP_SLL:  w_quick = a << w_shamt;
      // Overflow quotient equals a itself (the most-negative value).
      OP_DIV, OP_DIVU: w_quick = w_divZero ? ALL_ONES : a;
      OP_REM, OP_REMU: w_quick = w_divZero ? a : '0;
`ifdef ALU_MDU_FAST_MUL_EN
      OP_MUL:  w_quick = w_fastProd[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_quick = w_fastProd[2*WIDTH-1:WIDTH];
`endif
      default: w_quick = '0;
    endcase
  end

  // WIDTH is a power of two, so the final iteration is an all-ones count.
  assign w_lastIter = &r_count;

  logic [2*WIDTH-1:0] w_mulNext;
  logic [2*WIDTH-1:0] w_mulFinal;
  logic               w_mulNeg;
  logic [WIDTH-1:0]   w_mulResult;

  assign w_mulNext   = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_mulNeg    = ((r_op != OP_MULHU) & r_a[WIDTH-1]) ^
                       (((r_op == OP_MUL) || (r_op == OP_MULH)) & r_b[WIDTH-1]);
  assign w_mulFinal  = w_mulNeg ? -w_mulNext : w_mulNext;
  assign w_mulResult = (r_op == OP_MUL) ? w_mulFinal[WIDTH-1:0]
                                        : w_mulFinal[2*WIDTH-1:WIDTH];

  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic             w_divFits;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic [WIDTH-1:0] w_divResult;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so a set borrow bit
  // means the trial subtraction went negative.
  assign w_divShift = {r_rem, r_quo[WIDTH-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_divisor};
  assign w_divFits  = ~w_divDiff[WIDTH];
  assign w_remNext  = w_divFits ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
  assign w_quoNext  = {r_quo[WIDTH-2:0], w_divFits};

  // Quotient takes sign(a) XOR sign(b); remainder follows the dividend.
  always_comb begin
    w_divResult = w_remNext;
    case (r_op)
      OP_DIV:  w_divResult = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_quoNext : w_quoNext;
      OP_DIVU: w_divResult = w_quoNext;
      OP_REM:  w_divResult = r_a[WIDTH-1] ? -w_remNext : w_remNext;
      default: w_divResult = w_remNext;
    endcase
  end

  // Control FSM and datapath registers. done is a pulse, so it is cleared
  // every cycle and only set on the edge that writes a new result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_count   <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_count <= '0;
            if (w_single) begin
              result <= w_quick;
              zero   <= (w_quick == '0);
              done   <= 1'b1;
            end else if (w_isMul) begin
              r_state  <= S_MUL;
              busy     <= 1'b1;
              r_prod   <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, w_magA};
              r_mplier <= w_magB;
            end else begin
              r_state   <= S_DIV;
              busy      <= 1'b1;
              r_rem     <= '0;
              r_quo     <= w_magA;
              r_divisor <= w_magB;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_mulNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + SHAMT_W'(1);
          if (w_lastIter) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_mulResult;
            zero    <= (w_mulResult == '0);
          end
        end
        S_DIV: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count + SHAMT_W'(1);
          if (w_lastIter) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_divResult;
            zero    <= (w_divResult == '0);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu -- directed bench for alu_mdu (WIDTH=32). A behavioural model
// predicts busy/done/result/zero from plain 64-bit arithmetic and the
// handshake timing rules; a compare process checks the DUT against it every
// cycle, and directed vectors pin the model with hand-computed literals.
module tb_alu_mdu;

  localparam int W = 32;
`ifdef ALU_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLL    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int checks = 0;
  int failures = 0;

  bit           modelValid = 1'b0;
  bit           mBusy = 1'b0;
  bit           mDone = 1'b0;
  bit           mZero = 1'b1;
  logic [W-1:0] mResult = '0;
  logic [W-1:0] mPending = '0;
  int           mRemain = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Architectural result of one operation, from ordinary 64-bit arithmetic.
  function automatic logic [W-1:0] modelResult(input logic [4:0] fOp,
                                               input logic [W-1:0] fA,
                                               input logic [W-1:0] fB);
    longint          sA;
    longint          sB;
    longint          zB;
    longint unsigned uA;
    longint unsigned uB;
    logic [63:0]     wide;
    int              sh;
    bit              ovf;
    sA   = longint'($signed(fA));
    sB   = longint'($signed(fB));
    uA   = {32'd0, fA};
    uB   = {32'd0, fB};
    zB   = longint'(uB);
    sh   = int'(fB[4:0]);
    ovf  = (fA == 32'h8000_0000) && (fB == 32'hFFFF_FFFF);
    wide = '0;
    case (fOp)
      OP_ADD:  return fA + fB;
      OP_SUB:  return fA - fB;
      OP_AND:  return fA & fB;
      OP_OR:   return fA | fB;
      OP_XOR:  return fA ^ fB;
      OP_SLT:  return (sA < sB) ? 32'd1 : 32'd0;
      OP_SLTU: return (uA < uB) ? 32'd1 : 32'd0;
      OP_SRL:  return fA >> sh;
      OP_SRA:  begin wide = sA >>> sh; return wide[31:0]; end
      OP_SLL:  return fA << sh;
      OP_MUL:  begin wide = sA * sB; return wide[31:0]; end
      OP_MULH: begin wide = sA * sB; return wide[63:32]; end
      OP_MULHSU: begin wide = sA * zB; return wide[63:32]; end
      OP_MULHU:  begin wide = uA * uB; return wide[63:32]; end
      OP_DIV: begin
        if (fB == '0) return 32'hFFFF_FFFF;
        if (ovf) return fA;
        wide = sA / sB;
        return wide[31:0];
      end
      OP_DIVU: begin
        if (fB == '0) return 32'hFFFF_FFFF;
        return fA / fB;
      end
      OP_REM: begin
        if (fB == '0) return fA;
        if (ovf) return 32'd0;
        wide = sA % sB;
        return wide[31:0];
      end
      OP_REMU: begin
        if (fB == '0) return fA;
        return fA % fB;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from the accept edge's cycle to the cycle done is high.
  function automatic int modelLatency(input logic [4:0] fOp,
                                      input logic [W-1:0] fA,
                                      input logic [W-1:0] fB);
    bit signedDiv;
    signedDiv = (fOp == OP_DIV) || (fOp == OP_REM);
    if (fOp >= OP_DIV && fOp <= OP_REMU) begin
      if (fB == '0) return 1;
      if (signedDiv && fA == 32'h8000_0000 && fB == 32'hFFFF_FFFF) return 1;
      return DIV_LAT;
    end
    if (fOp >= OP_MUL && fOp <= OP_MULHU) return MUL_LAT;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Handshake model: sees the same inputs the DUT samples at each rising edge.
  initial begin
    int           lat;
    logic [W-1:0] res;
    forever begin
      @(posedge clk);
      if (reset) begin
        modelValid = 1'b1;
        mBusy      = 1'b0;
        mDone      = 1'b0;
        mResult    = '0;
        mZero      = 1'b1;
        mRemain    = 0;
      end else begin
        mDone = 1'b0;
        if (mBusy) begin
          mRemain--;
          if (mRemain == 0) begin
            mBusy   = 1'b0;
            mDone   = 1'b1;
            mResult = mPending;
            mZero   = (mPending == '0);
          end
        end else if (start) begin
          lat = modelLatency(op, a, b);
          res = modelResult(op, a, b);
          if (lat == 1) begin
            mDone   = 1'b1;
            mResult = res;
            mZero   = (res == '0);
          end else begin
            mBusy    = 1'b1;
            mRemain  = lat - 1;
            mPending = res;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        checkOutput("cycBusy",   W'(busy), W'(mBusy));
        checkOutput("cycDone",   W'(done), W'(mDone));
        checkOutput("cycResult", result,   mResult);
        checkOutput("cycZero",   W'(zero), W'(mZero));
      end
    end
  end

  // Drive one request for a single cycle from a falling edge, then scramble
  // the operands so the DUT must be working from its own captured copy.
  task automatic applyStimulus(input logic [4:0] sOp, input logic [W-1:0] sA,
                               input logic [W-1:0] sB);
    start = 1'b1;
    op    = sOp;
    a     = sA;
    b     = sB;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitDone(input int firstCycle, output int cycles, output int busyCycles);
    cycles     = firstCycle;
    busyCycles = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitDone timeout actual=no_done required=done_within_60");
    end
  endtask

  task automatic issueAndCheck(input string name, input logic [4:0] sOp,
                               input logic [W-1:0] sA, input logic [W-1:0] sB,
                               input logic [W-1:0] expRes, input int expLat);
    int cycles;
    int busyCycles;
    applyStimulus(sOp, sA, sB);
    waitDone(1, cycles, busyCycles);
    checkOutput(name, result, expRes);
    checkOutput({name, "Zero"}, W'(zero), W'(expRes == '0));
    checkOutput({name, "Lat"}, W'(cycles), W'(expLat));
    checkOutput({name, "BusyCyc"}, W'(busyCycles), W'(expLat - 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int busyCycles;
    int doneSeen;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rstBusy",   W'(busy), 32'd0);
    checkOutput("rstDone",   W'(done), 32'd0);
    checkOutput("rstResult", result,   32'd0);
    checkOutput("rstZero",   W'(zero), 32'd1);

    $display("[TB] ALU ops");
    issueAndCheck("addWrap", OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1);
    issueAndCheck("subZero", OP_SUB,  32'd5,         32'd5,         32'd0,         1);
    issueAndCheck("sra",     OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    issueAndCheck("srl",     OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    issueAndCheck("slt",     OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    issueAndCheck("sltu",    OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    issueAndCheck("sllMask", OP_SLL,  32'd1,         32'h25,        32'h20,        1);
    issueAndCheck("and",     OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    issueAndCheck("or",      OP_OR,   32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1);
    issueAndCheck("xor",     OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    issueAndCheck("badOp",   5'd31,   32'h1234_5678, 32'h1,         32'd0,         1);

    $display("[TB] multiply");
    issueAndCheck("mulh",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    issueAndCheck("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    issueAndCheck("mulNeg",  OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    issueAndCheck("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
    issueAndCheck("mulMinSq", OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);

    $display("[TB] divide");
    issueAndCheck("divNeg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    issueAndCheck("remNeg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    issueAndCheck("divu",    OP_DIVU, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    issueAndCheck("remu",    OP_REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    issueAndCheck("divZero", OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    issueAndCheck("remZero", OP_REM,  32'd5,         32'd0,         32'd5,         1);
    issueAndCheck("divuZero", OP_DIVU, 32'd9,        32'd0,         32'hFFFF_FFFF, 1);
    issueAndCheck("divOvf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issueAndCheck("remOvf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Back-to-back: the ADD is driven in the very cycle the DIVU reports done.
    $display("[TB] back-to-back issue");
    issueAndCheck("b2bDivu", OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    issueAndCheck("b2bAdd",  OP_ADD,  32'd2,   32'd3, 32'd5,  1);

    // A start pulsed mid-division must not disturb it or be queued.
    $display("[TB] start while busy");
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = OP_ADD;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    waitDone(7, cycles, busyCycles);
    checkOutput("busyStartRes", result, 32'd333);
    checkOutput("busyStartLat", W'(cycles), W'(DIV_LAT));

    // Reset ten cycles into a DIVU aborts it with no done pulse.
    $display("[TB] reset mid-operation");
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortBusy",   W'(busy), 32'd0);
    checkOutput("abortResult", result,   32'd0);
    checkOutput("abortZero",   W'(zero), 32'd1);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abortNoDone", W'(doneSeen), 32'd0);
    issueAndCheck("postAbort", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
